// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller:
// states, opcodes, funct codes and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUSRCB_REG   = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

endpackage

// File: rtl/mc_alu_decode.sv
// R-type funct decoder: maps funct to ALU control and flags
// encodings the datapath cannot execute.
module mc_alu_decode
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] aluc,
    output logic       valid
);

    // Only the five supported R-type functions are legal.
    always_comb begin
        aluc  = ALUC_ADD;
        valid = 1'b1;
        unique case (1'b1)
            (funct == FN_ADD): aluc = ALUC_ADD;
            (funct == FN_SUB): aluc = ALUC_SUB;
            (funct == FN_AND): aluc = ALUC_AND;
            (funct == FN_OR):  aluc = ALUC_OR;
            (funct == FN_SLT): aluc = ALUC_SLT;
            default:           valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle sequencing controller: state machine, datapath
// control decode and retired-instruction counter.
module mc_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       aluc,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] retire_count,
    output logic [3:0]       state
);

    state_e           state_q, state_d;
    logic             is_lw_q, is_lw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       dec_aluc;
    logic             dec_valid;

    mc_alu_decode u_alu_decode (
        .funct (funct),
        .aluc  (dec_aluc),
        .valid (dec_valid)
    );

    // State, load/store flavour and retire counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            is_lw_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            is_lw_q <= is_lw_d;
            cnt_q   <= cnt_d;
        end
    end

    // Remember lw vs sw at decode; opcode is not valid later.
    always_comb begin
        is_lw_d = is_lw_q;
        if (state_q == S_DECODE) begin
            is_lw_d = (opcode == OP_LW);
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (1'b1)
                    (opcode == OP_LW),
                    (opcode == OP_SW):   state_d = S_MEMADR;
                    (opcode == OP_RTYPE): begin
                        state_d = dec_valid ? S_EXEC : S_TRAP;
                    end
                    (opcode == OP_BEQ):  state_d = S_BRANCH;
                    (opcode == OP_ADDI): state_d = S_ADDIEX;
                    (opcode == OP_J):    state_d = S_JUMP;
                    default:             state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = is_lw_q ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
    end

    // Datapath control decode; mostly Moore, a few Mealy terms.
    always_comb begin
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PCSRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUSRCB_REG;
        aluc          = ALUC_AND;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        retire        = 1'b0;
        illegal       = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUSRCB_FOUR;
                aluc      = ALUC_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = ALUSRCB_IMMSH;
                aluc      = ALUC_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_IMM;
                aluc      = ALUC_ADD;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_REG;
                aluc      = dec_aluc;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                aluc          = ALUC_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PCSRC_ALUOUT;
                retire        = 1'b1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
                retire   = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

    assign retire_count = cnt_q;
    assign state        = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle vector table
// plus hand sequences for trap hold, reset and wrap.
module tb_mc_control;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic          mem_ready;
    logic          iord, mem_read, mem_write, ir_write;
    logic          pc_write, pc_write_cond;
    logic [1:0]    pc_src;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [2:0]    aluc;
    logic          reg_dst, mem_to_reg, reg_write;
    logic          retire, illegal;
    logic [CW-1:0] retire_count;
    logic [3:0]    state;
    logic [18:0]   outs;

    mc_control #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .mem_ready     (mem_ready),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .aluc          (aluc),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .retire        (retire),
        .illegal       (illegal),
        .retire_count  (retire_count),
        .state         (state)
    );

    assign outs = {iord, mem_read, mem_write, ir_write, pc_write,
                   pc_write_cond, pc_src, alu_src_a, alu_src_b,
                   aluc, reg_dst, mem_to_reg, reg_write, retire,
                   illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]    op;
        logic [5:0]    fn;
        logic          mr;
        logic [3:0]    st;
        logic [18:0]   o;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t          q[$];
    logic [CW-1:0] ecnt;
    int            ncmp;
    int            nbad;

    function automatic logic [18:0] o_fetch(input logic mr);
        return {3'b010, mr, mr, 1'b0, 2'b00, 1'b0, 2'b01,
                3'b010, 5'b0};
    endfunction
    function automatic logic [18:0] o_decode();
        return {6'b0, 2'b00, 1'b0, 2'b11, 3'b010, 5'b0};
    endfunction
    function automatic logic [18:0] o_memadr();
        return {6'b0, 2'b00, 1'b1, 2'b10, 3'b010, 5'b0};
    endfunction
    function automatic logic [18:0] o_memrd();
        return {2'b11, 4'b0, 2'b00, 1'b0, 2'b00, 3'b000, 5'b0};
    endfunction
    function automatic logic [18:0] o_memwr(input logic mr);
        return {3'b101, 3'b0, 2'b00, 1'b0, 2'b00, 3'b000,
                3'b000, mr, 1'b0};
    endfunction
    function automatic logic [18:0] o_exec(input logic [2:0] c);
        return {6'b0, 2'b00, 1'b1, 2'b00, c, 5'b0};
    endfunction
    function automatic logic [18:0] o_branch();
        return {5'b0, 1'b1, 2'b01, 1'b1, 2'b00, 3'b110, 5'b00010};
    endfunction
    function automatic logic [18:0] o_jump();
        return {4'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 3'b000,
                5'b00010};
    endfunction

    localparam logic [18:0] O_INIT   = 19'd0;
    localparam logic [18:0] O_MEMWB  = 19'b01110;
    localparam logic [18:0] O_ALUWB  = 19'b10110;
    localparam logic [18:0] O_ADDIWB = 19'b00110;
    localparam logic [18:0] O_TRAP   = 19'd1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn,
                       input logic mr, input logic [3:0] st,
                       input logic [18:0] o);
        q.push_back('{op, fn, mr, st, o, ecnt});
        if (o[1]) ecnt = ecnt + 1'b1;
    endtask

    task automatic run(input string tag);
        foreach (q[i]) begin
            opcode    = q[i].op;
            funct     = q[i].fn;
            mem_ready = q[i].mr;
            #1;
            chk($sformatf("%s[%0d] state", tag, i), 32'(state),
                32'(q[i].st));
            chk($sformatf("%s[%0d] outs", tag, i), 32'(outs),
                32'(q[i].o));
            chk($sformatf("%s[%0d] cnt", tag, i), 32'(retire_count),
                32'(q[i].cnt));
            tick();
        end
        q.delete();
    endtask

    task automatic do_reset();
        tick();
        rst_n     = 1'b0;
        opcode    = 6'h0;
        funct     = 6'h0;
        mem_ready = 1'b0;
        #1;
        chk("rst state", 32'(state), 32'd0);
        chk("rst outs", 32'(outs), 32'd0);
        chk("rst cnt", 32'(retire_count), 32'd0);
        tick();
        rst_n = 1'b1;
        ecnt  = '0;
        add(6'h3F, 6'h3F, 1'b1, 4'd0, O_INIT);
    endtask

    task automatic add_fetch();
        add(6'h3F, 6'h3F, 1'b1, 4'd1, o_fetch(1'b1));
    endtask

    task automatic add_r(input logic [5:0] fn, input logic [2:0] c);
        add_fetch();
        add(6'h00, fn, 1'b0, 4'd2, o_decode());
        add(6'h00, fn, 1'b0, 4'd7, o_exec(c));
        add(6'h3F, 6'h3F, 1'b0, 4'd8, O_ALUWB);
    endtask

    task automatic add_addi();
        add_fetch();
        add(6'h08, 6'h00, 1'b1, 4'd2, o_decode());
        add(6'h3F, 6'h3F, 1'b0, 4'd10, o_memadr());
        add(6'h3F, 6'h3F, 1'b0, 4'd11, O_ADDIWB);
    endtask

    task automatic add_j();
        add_fetch();
        add(6'h02, 6'h00, 1'b1, 4'd2, o_decode());
        add(6'h3F, 6'h3F, 1'b0, 4'd12, o_jump());
    endtask

    initial begin
        ncmp      = 0;
        nbad      = 0;
        ecnt      = '0;
        rst_n     = 1'b0;
        opcode    = 6'h0;
        funct     = 6'h0;
        mem_ready = 1'b0;

        // All R-type functions, then lw with stalls, sw/beq/j/addi.
        do_reset();
        add_r(6'h20, 3'b010);
        add_r(6'h22, 3'b110);
        add_r(6'h24, 3'b000);
        add_r(6'h25, 3'b001);
        add_r(6'h2A, 3'b111);
        add(6'h3F, 6'h3F, 1'b0, 4'd1, o_fetch(1'b0));
        add(6'h3F, 6'h3F, 1'b0, 4'd1, o_fetch(1'b0));
        add_fetch();
        add(6'h23, 6'h00, 1'b0, 4'd2, o_decode());
        add(6'h2B, 6'h3F, 1'b1, 4'd3, o_memadr());
        add(6'h3F, 6'h3F, 1'b0, 4'd4, o_memrd());
        add(6'h3F, 6'h3F, 1'b0, 4'd4, o_memrd());
        add(6'h3F, 6'h3F, 1'b0, 4'd4, o_memrd());
        add(6'h3F, 6'h3F, 1'b1, 4'd4, o_memrd());
        add(6'h3F, 6'h3F, 1'b1, 4'd5, O_MEMWB);
        add_fetch();
        add(6'h2B, 6'h00, 1'b1, 4'd2, o_decode());
        add(6'h23, 6'h3F, 1'b1, 4'd3, o_memadr());
        add(6'h3F, 6'h3F, 1'b0, 4'd6, o_memwr(1'b0));
        add(6'h3F, 6'h3F, 1'b1, 4'd6, o_memwr(1'b1));
        add_fetch();
        add(6'h04, 6'h00, 1'b1, 4'd2, o_decode());
        add(6'h3F, 6'h3F, 1'b0, 4'd9, o_branch());
        add_j();
        add_addi();
        add_fetch();
        run("seq");
        chk("seq total", 32'(retire_count), 32'd10);

        // Unknown opcode traps and holds for 20 cycles.
        do_reset();
        add_fetch();
        add(6'h3F, 6'h20, 1'b1, 4'd2, o_decode());
        add(6'h00, 6'h20, 1'b1, 4'd15, O_TRAP);
        run("trapop");
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            opcode    = 6'($urandom_range(0, 63));
            funct     = 6'h20;
            #1;
            chk($sformatf("trap hold %0d", i),
                32'({state, illegal, retire, reg_write, mem_write}),
                32'({4'd15, 4'b1000}));
            chk($sformatf("trap cnt %0d", i), 32'(retire_count),
                32'd0);
            tick();
        end

        // Illegal R-type funct traps too.
        do_reset();
        add_fetch();
        add(6'h00, 6'h03, 1'b1, 4'd2, o_decode());
        add(6'h00, 6'h20, 1'b1, 4'd15, O_TRAP);
        run("trapfn");

        // Reset mid MEMRD wait, then resume cleanly.
        do_reset();
        add_j();
        add_fetch();
        add(6'h23, 6'h00, 1'b1, 4'd2, o_decode());
        add(6'h3F, 6'h3F, 1'b1, 4'd3, o_memadr());
        add(6'h3F, 6'h3F, 1'b0, 4'd4, o_memrd());
        add(6'h3F, 6'h3F, 1'b0, 4'd4, o_memrd());
        run("midrd");
        chk("midrd pre state", 32'(state), 32'd4);
        chk("midrd pre cnt", 32'(retire_count), 32'd1);
        do_reset();
        add_j();
        add_fetch();
        run("resume");

        // Counter wrap with 17 addi.
        do_reset();
        for (int i = 0; i < 17; i++) add_addi();
        add_fetch();
        run("wrap");
        chk("wrap final", 32'(retire_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle sequencing controller for the single-ported MIPS datapath: instruction decode, register file and sign extender, ALU, and one shared instruction/data memory. It walks each instruction through fetch, decode, execute, memory and writeback states. Each cycle it drives the datapath's mux selects, write enables and 3-bit ALU control. It also stalls on a memory-ready handshake, traps on unsupported encodings, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  instruction[31:26] from the instruction register
- funct  in  6  instruction[5:0] from the instruction register
- mem_ready  in  1  memory completes the current access this cycle
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- aluc  out  3  000 = AND, 001 = OR, 010 = ADD, 110 = SUB, 111 = SLT
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = memory data register
- reg_write  out  1  register file write enable
- retire  out  1  one-cycle pulse per completed instruction
- illegal  out  1  controller trapped
- retire_count  out  CNT_W  retired instructions, wraps
- state  out  4  current state (debug)

## Operation
- State encodings: INIT = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6, EXEC = 7, ALUWB = 8, BRANCH = 9, ADDIEX = 10, ADDIWB = 11, JUMP = 12, TRAP = 15.
- Any output not listed for a state is 0.
- INIT: all outputs 0; goes to FETCH.
- FETCH: mem_read = 1, alu_src_b = 01, aluc = ADD; ir_write = pc_write = mem_ready. Stays in FETCH while mem_ready = 0, otherwise goes to DECODE.
- DECODE: alu_src_b = 11, aluc = ADD. Branches on opcode:
  - opcode 0x23 (lw) or 0x2B (sw) -> MEMADR
  - opcode 0x00 with funct in {0x20, 0x22, 0x24, 0x25, 0x2A} -> EXEC
  - opcode 0x04 (beq) -> BRANCH
  - opcode 0x08 (addi) -> ADDIEX
  - opcode 0x02 (j) -> JUMP
  - anything else -> TRAP
- MEMADR and ADDIEX: alu_src_a = 1, alu_src_b = 10, aluc = ADD. MEMADR goes to MEMRD if lw, MEMWR if sw; ADDIEX goes to ADDIWB.
- MEMRD: iord = 1, mem_read = 1; held until mem_ready, then -> MEMWB.
- MEMWB: mem_to_reg = 1, reg_write = 1, retire; -> FETCH.
- MEMWR: iord = 1, mem_write = 1; held until mem_ready. retire pulses in the mem_ready cycle, then -> FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00. aluc decoded from funct: 0x20 -> 010, 0x22 -> 110, 0x24 -> 000, 0x25 -> 001, 0x2A -> 111. -> ALUWB.
- ALUWB: reg_dst = 1, reg_write = 1, retire; -> FETCH.
- ADDIWB: reg_write = 1, retire; -> FETCH.
- BRANCH: alu_src_a = 1, aluc = SUB, pc_write_cond = 1, pc_src = 01, retire; -> FETCH.
- JUMP: pc_write = 1, pc_src = 10, retire; -> FETCH.
- TRAP: illegal = 1, all other outputs 0. Absorbing: only reset leaves it.
- retire_count increments by 1 on every retire cycle; it wraps from 2^CNT_W - 1 to 0.

## Timing
- Reset values: state = INIT, retire_count = 0, illegal = 0, every other output 0.
- Reset asserts asynchronously; first FETCH is the second rising edge after rst_n deasserts.
- Control outputs are decoded combinationally from state. The Mealy exceptions are ir_write, pc_write in FETCH, retire in MEMWR, and aluc in EXEC (from funct).
- Latency with mem_ready held 1, FETCH to next FETCH: j = 3, beq = 3, R-type = 4, addi = 4, sw = 4, lw = 5 cycles.
- Each cycle of mem_ready = 0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Request signals stay stable during the wait.
- mem_ready is ignored in all other states.
- rst_n low in any state, including mid-wait or TRAP: immediate return to INIT, counter cleared.
- opcode/funct are sampled only in DECODE and EXEC; they are don't-care elsewhere.

## Structure
- Package mc_pkg: state enum, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), funct constants, ALUC_* codes, PCSRC_*/ALUSRCB_* encodings.
- One sub-module: mc_alu_decode, combinational funct -> {aluc, valid}. It is used in DECODE for legality and in EXEC for aluc.
- Top holds the state register, next-state logic, output decode and counter.

## Test plan
- Reset then add (opcode 0, funct 0x20), mem_ready = 1 -> states 0,1,2,7,8,1; EXEC aluc = 010; ALUWB reg_dst = 1, reg_write = 1; retire_count = 1.
- lw with mem_ready low 2 cycles in FETCH and 3 cycles in MEMRD -> 10 cycles FETCH to FETCH; iord = 1 throughout MEMRD; single retire in MEMWB.
- sw then beq then j back-to-back -> MEMWR mem_write = 1; BRANCH pc_write_cond = 1, pc_src = 01, aluc = 110; JUMP pc_write = 1, pc_src = 10; retire_count = 3.
- Opcode 0x3F, and R-type funct 0x03 -> TRAP after DECODE; illegal = 1 held for 20 cycles; no retire, reg_write, mem_write.
- rst_n pulsed low mid-MEMRD wait -> outputs 0 immediately, retire_count = 0, state = INIT, normal fetch resumes.
- CNT_W = 4, 17 addi instructions -> retire_count wraps 15 -> 0, reads 1 at the end.
